controlador_medida_dht11: RTL and testbench

Sequences the interface_dht11 block.
- Issues measurement triggers periodically or on demand.
- Supervises each transaction with a timeout and bounded retries.
- Holds the last good temperature/humidity pair for the rest of the design.
- Sits between the top-level control logic and interface_dht11; all sensor traffic goes through it.

---
 rtl/controlador_medida_dht11_pkg.sv | 17 +
 rtl/contador_m.sv | 28 ++
 rtl/controlador_medida_dht11.sv | 127 ++++++++++++
 tb/tb_controlador_medida_dht11.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_medida_dht11_pkg.sv
// Shared state codes and default timing parameters for the DHT11 measurement controller.
package controlador_medida_dht11_pkg;

   typedef enum logic [3:0] {
      StOcioso   = 4'd0,
      StEspera   = 4'd1,
      StDispara  = 4'd2,
      StAguarda  = 4'd3,
      StArmazena = 4'd4,
      StFalha    = 4'd5
   } estado_t;

   localparam int unsigned PERIODO_CICLOS_PADRAO = 100_000_000;
   localparam int unsigned TIMEOUT_CICLOS_PADRAO = 5_000_000;
   localparam int unsigned MAX_TENTATIVAS_PADRAO = 3;

endpackage

// File: rtl/contador_m.sv
// Modulo-N counter: zera clears (priority), conta advances, fim flags the last count N-1.
module contador_m #(
   parameter int unsigned N = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);

   localparam int unsigned LARG = (N > 1) ? $clog2(N) : 1;

   logic [LARG-1:0] valor_q;

   assign fim = (valor_q == LARG'(N - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valor_q <= '0;
      end else if (zera) begin
         valor_q <= '0;
      end else if (conta) begin
         valor_q <= fim ? '0 : valor_q + LARG'(1);
      end
   end

endmodule

// File: rtl/controlador_medida_dht11.sv
// Sequences interface_dht11: periodic/on-demand triggers, per-attempt timeout, bounded retries,
// and holds the last good temperature/humidity pair.
module controlador_medida_dht11
   import controlador_medida_dht11_pkg::*;
#(
   parameter int unsigned PERIODO_CICLOS = PERIODO_CICLOS_PADRAO,
   parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
   parameter int unsigned MAX_TENTATIVAS = MAX_TENTATIVAS_PADRAO
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ligar,
   input  logic        medir_agora,
   input  logic        pronto_medida,
   input  logic [15:0] temperatura_in,
   input  logic [15:0] umidade_in,
   output logic        medir_dht11,
   output logic [15:0] temperatura,
   output logic [15:0] umidade,
   output logic        medida_valida,
   output logic        erro,
   output logic [7:0]  num_falhas,
   output logic [3:0]  db_estado
);

   localparam int unsigned LARG_TENT = (MAX_TENTATIVAS > 1) ? $clog2(MAX_TENTATIVAS) : 1;

   estado_t              estado_q;
   logic [LARG_TENT-1:0] tentativas_q;
   logic                 esgotou;
   logic                 zera_periodo, conta_periodo, fim_periodo;
   logic                 zera_timeout, conta_timeout, fim_timeout;

   assign esgotou   = (32'(tentativas_q) + 32'd1) >= MAX_TENTATIVAS;
   assign db_estado = estado_q;

   // Period count restarts whenever a measurement concludes or the periodic mode is dropped.
   assign zera_periodo  = (estado_q == StArmazena) || ((estado_q == StFalha) && esgotou) ||
                          ((estado_q == StEspera) && !ligar);
   assign conta_periodo = (estado_q == StEspera);
   assign zera_timeout  = (estado_q == StDispara);
   assign conta_timeout = (estado_q == StAguarda);

   contador_m #(
      .N (PERIODO_CICLOS)
   ) u_periodo (
      .clock (clock),
      .reset (reset),
      .zera  (zera_periodo),
      .conta (conta_periodo),
      .fim   (fim_periodo)
   );

   contador_m #(
      .N (TIMEOUT_CICLOS)
   ) u_timeout (
      .clock (clock),
      .reset (reset),
      .zera  (zera_timeout),
      .conta (conta_timeout),
      .fim   (fim_timeout)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q      <= StOcioso;
         tentativas_q  <= '0;
         medir_dht11   <= 1'b0;
         temperatura   <= '0;
         umidade       <= '0;
         medida_valida <= 1'b0;
         erro          <= 1'b0;
         num_falhas    <= '0;
      end else begin
         // Trigger is raised on every transition into StDispara, so it is high exactly there.
         medir_dht11 <= 1'b0;
         unique case (estado_q)
            StOcioso: begin
               tentativas_q <= '0;
               if (ligar || medir_agora) begin
                  estado_q    <= StDispara;
                  medir_dht11 <= 1'b1;
               end
            end
            StDispara: estado_q <= StAguarda;
            StAguarda: begin
               if (pronto_medida) begin
                  temperatura <= temperatura_in;
                  umidade     <= umidade_in;
                  estado_q    <= StArmazena;
               end else if (fim_timeout) begin
                  estado_q <= StFalha;
               end
            end
            StArmazena: begin
               medida_valida <= 1'b1;
               erro          <= 1'b0;
               tentativas_q  <= '0;
               estado_q      <= ligar ? StEspera : StOcioso;
            end
            StFalha: begin
               if (num_falhas != 8'hff) num_falhas <= num_falhas + 8'd1;
               if (!esgotou) begin
                  tentativas_q <= tentativas_q + LARG_TENT'(1);
                  estado_q     <= StDispara;
                  medir_dht11  <= 1'b1;
               end else begin
                  erro          <= 1'b1;
                  medida_valida <= 1'b0;
                  tentativas_q  <= '0;
                  estado_q      <= ligar ? StEspera : StOcioso;
               end
            end
            StEspera: begin
               if (!ligar) begin
                  estado_q <= StOcioso;
               end else if (medir_agora || fim_periodo) begin
                  estado_q    <= StDispara;
                  medir_dht11 <= 1'b1;
               end
            end
            default: estado_q <= StOcioso;
         endcase
      end
   end

endmodule

// File: tb/tb_controlador_medida_dht11.sv
// Scoreboard bench: stimulus queues expected trigger cycles and measurement results,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_controlador_medida_dht11;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ligar = 1'b0;
   logic        medir_agora = 1'b0;
   logic        pronto_medida = 1'b0;
   logic [15:0] temperatura_in = '0;
   logic [15:0] umidade_in = '0;
   logic        medir_dht11;
   logic [15:0] temperatura;
   logic [15:0] umidade;
   logic        medida_valida;
   logic        erro;
   logic [7:0]  num_falhas;
   logic [3:0]  db_estado;

   controlador_medida_dht11 #(
      .PERIODO_CICLOS (50),
      .TIMEOUT_CICLOS (20),
      .MAX_TENTATIVAS (3)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ligar          (ligar),
      .medir_agora    (medir_agora),
      .pronto_medida  (pronto_medida),
      .temperatura_in (temperatura_in),
      .umidade_in     (umidade_in),
      .medir_dht11    (medir_dht11),
      .temperatura    (temperatura),
      .umidade        (umidade),
      .medida_valida  (medida_valida),
      .erro           (erro),
      .num_falhas     (num_falhas),
      .db_estado      (db_estado)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] temp;
      logic [15:0] umid;
      logic        mv;
      logic        erro;
      logic [7:0]  nf;
   } resultado_t;

   int         ciclo = 0;
   int         n_assert = 0;
   int         n_fail = 0;
   int         exp_pulsos[$];
   resultado_t exp_res[$];
   logic [15:0] mod_temp = '0;
   logic [15:0] mod_umid = '0;
   logic [7:0]  mod_nf = '0;
   logic [3:0]  estado_ant = '0;

   always @(posedge clock) ciclo <= ciclo + 1;

   task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      n_assert++;
      if (atual !== esperado) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, ciclo);
      end
   endtask

   // Monitor: trigger pulses and measurement completions (leaving ARMAZENA/FALHA for rest).
   always @(negedge clock) begin
      if (!reset) begin
         if (medir_dht11) begin
            if (exp_pulsos.size() == 0) begin
               n_assert++;
               n_fail++;
               $display("FAIL pulso_inesperado: got pulse at cycle %0d expected none", ciclo);
            end else begin
               check("ciclo_pulso", ciclo, exp_pulsos.pop_front());
            end
         end
         if ((estado_ant == 4'd4 || estado_ant == 4'd5) && (db_estado == 4'd0 || db_estado == 4'd1))
         begin
            if (exp_res.size() == 0) begin
               n_assert++;
               n_fail++;
               $display("FAIL resultado_inesperado: got completion at cycle %0d expected none", ciclo);
            end else begin
               resultado_t r;
               r = exp_res.pop_front();
               check("res_temperatura", temperatura, r.temp);
               check("res_umidade", umidade, r.umid);
               check("res_medida_valida", medida_valida, r.mv);
               check("res_erro", erro, r.erro);
               check("res_num_falhas", num_falhas, r.nf);
            end
         end
      end
      estado_ant = db_estado;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Called at the negedge showing a trigger; pronto is sampled d edges after the trigger.
   task automatic responder(input int d, input logic [15:0] t, input logic [15:0] u);
      exp_res.push_back('{temp: t, umid: u, mv: 1'b1, erro: 1'b0, nf: mod_nf});
      mod_temp = t;
      mod_umid = u;
      tick(d - 1);
      pronto_medida  = 1'b1;
      temperatura_in = t;
      umidade_in     = u;
      tick(1);
      pronto_medida  = 1'b0;
      temperatura_in = 16'h0f0f;
      umidade_in     = 16'hf0f0;
   endtask

   task automatic pedir;
      medir_agora = 1'b1;
      exp_pulsos.push_back(ciclo + 1);
      tick(1);
      medir_agora = 1'b0;
   endtask

   task automatic check_zerado(input string pre);
      check({pre, "_temperatura"}, temperatura, 0);
      check({pre, "_umidade"}, umidade, 0);
      check({pre, "_medida_valida"}, medida_valida, 0);
      check({pre, "_erro"}, erro, 0);
      check({pre, "_num_falhas"}, num_falhas, 0);
      check({pre, "_medir_dht11"}, medir_dht11, 0);
      check({pre, "_db_estado"}, db_estado, 0);
   endtask

   initial begin
      tick(3);
      check_zerado("reset");
      reset = 1'b0;
      tick(2);
      check("ocioso_apos_reset", db_estado, 0);

      // 1: on-demand success, data visible on capture edge, valid one cycle later
      pedir();
      tick(4);
      pronto_medida  = 1'b1;
      temperatura_in = 16'haaaa;
      umidade_in     = 16'hbbbb;
      exp_res.push_back('{temp: 16'haaaa, umid: 16'hbbbb, mv: 1'b1, erro: 1'b0, nf: 8'd0});
      mod_temp = 16'haaaa;
      mod_umid = 16'hbbbb;
      tick(1);
      pronto_medida = 1'b0;
      check("captura_temperatura", temperatura, 16'haaaa);
      check("captura_mv_ainda_0", medida_valida, 0);
      tick(1);
      check("t1_estado_final", db_estado, 0);

      // 2: periodic mode, 50 waiting cycles between transactions, stops when ligar drops
      ligar = 1'b1;
      exp_pulsos.push_back(ciclo + 1);
      tick(1);
      responder(5, 16'h0101, 16'h0202);
      exp_pulsos.push_back(ciclo + 51);
      tick(51);
      responder(5, 16'h0303, 16'h0404);
      tick(8);
      ligar = 1'b0;
      tick(100);
      check("t2_ocioso", db_estado, 0);

      // 3: first attempt times out, retry 22 cycles later succeeds
      pedir();
      exp_pulsos.push_back(ciclo + 22);
      mod_nf = mod_nf + 8'd1;
      tick(22);
      responder(5, 16'h1234, 16'h5678);
      tick(1);

      // 5a: pronto on the timeout edge wins
      pedir();
      responder(21, 16'h5555, 16'h6666);
      check("pronto_no_timeout", db_estado, 4);
      tick(1);

      // 5b: pronto while waiting in ESPERA is ignored
      ligar = 1'b1;
      exp_pulsos.push_back(ciclo + 1);
      tick(1);
      responder(5, 16'h7777, 16'h8888);
      tick(3);
      pronto_medida  = 1'b1;
      temperatura_in = 16'hdead;
      umidade_in     = 16'hdead;
      tick(1);
      pronto_medida = 1'b0;
      check("espera_estado", db_estado, 1);
      check("espera_temp_mantida", temperatura, mod_temp);
      check("espera_umid_mantida", umidade, mod_umid);
      ligar = 1'b0;
      tick(2);
      check("espera_para_ocioso", db_estado, 0);

      // 5c: medir_agora during AGUARDA produces no extra trigger
      pedir();
      tick(2);
      medir_agora = 1'b1;
      tick(1);
      medir_agora = 1'b0;
      responder(2, 16'h9999, 16'haaa0);
      tick(30);

      // 6: asynchronous reset mid-AGUARDA, then normal operation
      pedir();
      tick(3);
      check("aguarda_antes_reset", db_estado, 3);
      reset = 1'b1;
      #1;
      check_zerado("reset_async");
      mod_temp = '0;
      mod_umid = '0;
      mod_nf   = '0;
      tick(2);
      reset = 1'b0;
      tick(1);
      pedir();
      responder(5, 16'hcafe, 16'hbeef);
      tick(1);

      // 4: all three attempts time out; data held, erro raised
      pedir();
      exp_pulsos.push_back(ciclo + 22);
      exp_pulsos.push_back(ciclo + 44);
      mod_nf = mod_nf + 8'd3;
      exp_res.push_back('{temp: mod_temp, umid: mod_umid, mv: 1'b0, erro: 1'b1, nf: mod_nf});
      tick(80);
      check("t4_ocioso", db_estado, 0);

      check("pulsos_pendentes", exp_pulsos.size(), 0);
      check("resultados_pendentes", exp_res.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
